mips_mc_core: RTL

- Next-generation multicycle MIPS core: a single-memory-port CPU executing one instruction over 3-5 states.
- Generalised over the previous multicycle datapath:
  - parametrised reset vector;
  - variable-latency memory via a ready handshake;
  - bounded memory-wait timeout;
  - a halting state for BREAK and illegal opcodes;
  - a retired-instruction counter.
- Sits between the testbench/system memory model and nothing else; it is the top CPU block.

---
 rtl/mips_mc_core_if.sv | 19 +
 rtl/mips_mc_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_core_if.sv
// Single-port memory bus between the multicycle core (master) and system memory (slave).
interface mips_mc_core_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_rd_ena;
    logic        mem_wr_ena;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_wr_data, mem_rd_ena, mem_wr_ena,
        input  mem_rd_data, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wr_data, mem_rd_ena, mem_wr_ena,
        output mem_rd_data, mem_ready
    );
endinterface

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core: one shared memory port, ready handshake with timeout,
// HALT state for BREAK / illegal encodings / bus errors, retired-instruction counter.
module mips_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstb,
    mips_mc_core_if.master   bus,
    output logic [31:0]      PC,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]      aluOut_q, aluOut_d, mdr_q, mdr_d;
    logic [7:0]       waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0] instrCnt_q, instrCnt_d;
    logic             illegal_q, illegal_d, busErr_q, busErr_d;
    logic [31:0]      gpr_q [32];

    logic        gprWe;
    logic [4:0]  gprAddr;
    logic [31:0] gprData;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] immSext;
    logic        accessState, dataState;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign immSext = {{16{ir_q[15]}}, ir_q[15:0]};

    assign dataState   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign accessState = dataState || (state_q == S_FETCH);

    // Strobes are Moore outputs, gated off while reset is held.
    assign bus.mem_rd_ena  = rstb && ((state_q == S_FETCH) || (state_q == S_MEM_RD));
    assign bus.mem_wr_ena  = rstb && (state_q == S_MEM_WR);
    assign bus.mem_addr    = dataState ? aluOut_q : pc_q;
    assign bus.mem_wr_data = b_q;

    assign PC          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign bus_err     = busErr_q;
    assign instr_count = instrCnt_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        aluOut_d   = aluOut_q;
        mdr_d      = mdr_q;
        waitCnt_d  = '0;
        instrCnt_d = instrCnt_q;
        illegal_d  = illegal_q;
        busErr_d   = busErr_q;
        gprWe      = 1'b0;
        gprAddr    = rt;
        gprData    = aluOut_q;

        case (state_q)
            S_FETCH: if (bus.mem_ready) begin
                ir_d    = bus.mem_rd_data;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d      = gpr_q[rs];
                b_d      = gpr_q[rt];
                aluOut_d = pc_q + (immSext << 2);
                case (opcode)
                    OP_RTYPE: begin
                        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                            state_d = S_EXEC_R;
                        end else begin
                            // BREAK (funct 0x0D) halts cleanly; anything else is illegal
                            state_d   = S_HALT;
                            illegal_d = (funct != 6'h0D);
                        end
                    end
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                case (funct)
                    FN_ADD:  aluOut_d = a_q + b_q;
                    FN_SUB:  aluOut_d = a_q - b_q;
                    FN_AND:  aluOut_d = a_q & b_q;
                    FN_OR:   aluOut_d = a_q | b_q;
                    FN_SLT:  aluOut_d = {31'd0, ($signed(a_q) < $signed(b_q))};
                    default: aluOut_d = aluOut_q;
                endcase
                state_d = S_WB_R;
            end
            S_EXEC_I: begin
                aluOut_d = a_q + immSext;
                state_d  = S_WB_I;
            end
            S_WB_R, S_WB_I: begin
                gprWe      = 1'b1;
                gprAddr    = (state_q == S_WB_R) ? rd : rt;
                state_d    = S_FETCH;
                instrCnt_d = instrCnt_q + CNT_W'(1);
            end
            S_MEM_ADDR: begin
                aluOut_d = a_q + immSext;
                state_d  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: if (bus.mem_ready) begin
                mdr_d   = bus.mem_rd_data;
                state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                gprWe      = 1'b1;
                gprData    = mdr_q;
                state_d    = S_FETCH;
                instrCnt_d = instrCnt_q + CNT_W'(1);
            end
            S_MEM_WR: if (bus.mem_ready) begin
                state_d    = S_FETCH;
                instrCnt_d = instrCnt_q + CNT_W'(1);
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = aluOut_q;
                state_d    = S_FETCH;
                instrCnt_d = instrCnt_q + CNT_W'(1);
            end
            S_JUMP: begin
                pc_d       = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d    = S_FETCH;
                instrCnt_d = instrCnt_q + CNT_W'(1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // A stalled access either counts another wait cycle or gives up with a bus error.
        if (accessState && !bus.mem_ready) begin
            if (waitCnt_q == WAIT_LIMIT) begin
                state_d  = S_HALT;
                busErr_d = 1'b1;
            end else begin
                waitCnt_d = waitCnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            aluOut_q   <= '0;
            mdr_q      <= '0;
            waitCnt_q  <= '0;
            instrCnt_q <= '0;
            illegal_q  <= 1'b0;
            busErr_q   <= 1'b0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            aluOut_q   <= aluOut_d;
            mdr_q      <= mdr_d;
            waitCnt_q  <= waitCnt_d;
            instrCnt_q <= instrCnt_d;
            illegal_q  <= illegal_d;
            busErr_q   <= busErr_d;
            if (gprWe && (gprAddr != 5'd0)) gpr_q[gprAddr] <= gprData;
        end
    end
endmodule
